// File: rtl/apb_completer_regs.sv
// APB completer with a bank of byte-strobed registers, programmable wait states,
// address/privilege checking and registered response outputs.
module apb_completer_regs #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 64,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned PRIV_BASE   = 32'hC0
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [2:0]              pprot,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);

    localparam int unsigned IdxW = $clog2(NUM_REGS);
    localparam int unsigned CntW = 4;
    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] RegSpan  = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [ADDR_WIDTH-1:0] PrivBase = ADDR_WIDTH'(PRIV_BASE);
    localparam logic [CntW-1:0]       WaitMax  = CntW'(WAIT_STATES);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e                state_q, state_d, phase;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic            acc_err;
    logic [IdxW-1:0] idx;
    logic            unused_prot;

    assign unused_prot = ^pprot[2:1];
    assign idx         = paddr[IdxW+1:2];
    assign acc_err     = (paddr[1:0] != 2'b00) || (paddr >= RegSpan) ||
                         ((paddr >= PrivBase) && !pprot[0]);

    // SETUP lasts exactly one bus cycle, so it is recognised from the bus itself
    // while the register only needs to remember that an access phase is running.
    always_comb begin
        if (state_q == StAccess) begin
            phase = StAccess;
        end else if (psel && !penable) begin
            phase = StSetup;
        end else begin
            phase = StIdle;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        unique case (phase)
            StSetup: begin
                state_d = StAccess;
                cnt_d   = '0;
            end
            StAccess: begin
                if (!psel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (pready_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (pwrite && !acc_err) begin
                        for (int b = 0; b < NumBytes; b++) begin
                            if (pstrb[b]) begin
                                regs_d[idx][8*b +: 8] = pwdata[8*b +: 8];
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Address and controls are held for the whole transfer, so the response
        // for the next cycle can be decoded from the current bus values.
        pready_d  = (state_d == StAccess) && (cnt_d == WaitMax);
        pslverr_d = pready_d && acc_err;
        prdata_d  = (pready_d && !acc_err && !pwrite) ? regs_q[idx] : '0;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            regs_q    <= regs_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Randomised bench for apb_completer_regs: two instances (one and zero wait states)
// share the bus and are checked every cycle against a transaction-level model.
module tb_apb_completer_regs;

    localparam int WS0   = 1;
    localparam int WS1   = 0;
    localparam int NREGS = 64;
    localparam logic [31:0] PRIV = 32'hC0;

    logic        pclk;
    logic        preset_n;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [1:0]  pready;
    logic [1:0]  pslverr;
    logic [31:0] prdata [2];

    logic [31:0] mdl [2][NREGS];
    logic        exp_rdy [2];
    logic        exp_err [2];
    logic [31:0] exp_dat [2];

    int n_cmp = 0;
    int n_err = 0;

    apb_completer_regs #(.WAIT_STATES(WS0)) u_dut0 (
        .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pprot(pprot),
        .psel(psel[0]), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0])
    );

    apb_completer_regs #(.WAIT_STATES(WS1)) u_dut1 (
        .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pprot(pprot),
        .psel(psel[1]), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic m_err(input logic [31:0] a, input logic [2:0] p);
        return (a[1:0] != 2'b00) || (a >= 32'(NREGS * 4)) || ((a >= PRIV) && !p[0]);
    endfunction

    task automatic set_idle_exp();
        for (int d = 0; d < 2; d++) begin
            exp_rdy[d] = 1'b0;
            exp_err[d] = 1'b0;
            exp_dat[d] = '0;
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NREGS; i++) begin
                mdl[d][i] = '0;
            end
        end
    endtask

    // Every cycle: outputs must be silent except in the one completion cycle.
    always @(negedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("pready%0d", d), 32'(pready[d]), 32'(exp_rdy[d]));
            chk($sformatf("pslverr%0d", d), 32'(pslverr[d]), 32'(exp_err[d]));
            chk($sformatf("prdata%0d", d), prdata[d], exp_dat[d]);
        end
    end

    // Starts and ends at posedge+1; abort_at names the access cycle that drops psel.
    task automatic xfer(input int d, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                        input int abort_at, output logic [31:0] rd, output logic er);
        int   ws;
        logic e;
        ws = (d == 0) ? WS0 : WS1;
        e  = m_err(a, pr);
        rd = '0;
        er = 1'b0;
        psel = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        paddr = a;
        pwrite = w;
        pwdata = wd;
        pstrb = st;
        pprot = pr;
        set_idle_exp();
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int j = 1; j <= ws + 1; j++) begin
            if (j == abort_at) begin
                psel = '0;
                penable = 1'b0;
                @(posedge pclk); #1;
                return;
            end
            if (j == ws + 1) begin
                exp_rdy[d] = 1'b1;
                exp_err[d] = e;
                exp_dat[d] = (!w && !e) ? mdl[d][a[7:2]] : '0;
                @(negedge pclk);
                rd = prdata[d];
                er = pslverr[d];
                @(posedge pclk); #1;
                if (w && !e) begin
                    for (int b = 0; b < 4; b++) begin
                        if (st[b]) mdl[d][a[7:2]][8*b +: 8] = wd[8*b +: 8];
                    end
                end
            end else begin
                @(posedge pclk); #1;
            end
        end
        psel = '0;
        penable = 1'b0;
        set_idle_exp();
    endtask

    // Idle cycles with stray penable and address noise that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            psel = '0;
            penable = 1'($urandom_range(0, 1));
            paddr = $urandom;
            set_idle_exp();
            @(posedge pclk); #1;
        end
        penable = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            1:       a = 32'h100 + 32'($urandom_range(0, 63)) * 4;
            2:       a = $urandom;
            3, 4:    a = PRIV + 32'($urandom_range(0, 15)) * 4;
            5:       a = 32'($urandom_range(0, 63)) * 4;
            default: a = 32'($urandom_range(0, 7)) * 4;
        endcase
        return a;
    endfunction

    task automatic rnd_burst(input int n);
        logic [31:0] rd;
        logic        er;
        int          d;
        for (int k = 0; k < n; k++) begin
            d = $urandom_range(0, 1);
            xfer(d, rnd_addr(), 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                 3'($urandom_range(0, 7)),
                 (d == 0 && $urandom_range(0, 9) == 0) ? 1 : 0, rd, er);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        preset_n = 1'b0;
        psel = '0;
        penable = 1'b0;
        paddr = '0;
        pwrite = 1'b0;
        pwdata = '0;
        pstrb = '0;
        pprot = '0;
        set_idle_exp();
        clear_model();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_pready", 32'(pready[d]), 32'h0);
            chk("rst_pslverr", 32'(pslverr[d]), 32'h0);
            chk("rst_prdata", prdata[d], 32'h0);
        end
        repeat (2) @(posedge pclk);
        #3 preset_n = 1'b1;
        @(posedge pclk); #1;

        // One wait state: write then unprivileged read of 0x84.
        xfer(0, 32'h84, 1'b1, 32'h12345678, 4'hF, 3'b010, 0, rd, er);
        chk("w84_err", 32'(er), 32'h0);
        xfer(0, 32'h84, 1'b0, 32'h0, 4'hF, 3'b000, 0, rd, er);
        chk("r84_data", rd, 32'h12345678);
        chk("r84_err", 32'(er), 32'h0);

        // Partial strobe merges into the existing word.
        xfer(0, 32'h10, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, 0, rd, er);
        xfer(0, 32'h10, 1'b1, 32'h000000AA, 4'h1, 3'b000, 0, rd, er);
        xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd, er);
        chk("r10_merge", rd, 32'hFFFFFFAA);

        // Error responses.
        xfer(0, 32'h102, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        chk("r102_err", 32'(er), 32'h1);
        chk("r102_data", rd, 32'h0);
        xfer(0, 32'h100, 1'b1, 32'hCAFEBABE, 4'hF, 3'b001, 0, rd, er);
        chk("w100_err", 32'(er), 32'h1);
        xfer(0, 32'hC4, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 0, rd, er);
        chk("wC4_err", 32'(er), 32'h1);
        xfer(0, 32'hC4, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        chk("rC4_data", rd, 32'h0);
        chk("rC4_err", 32'(er), 32'h0);

        // Zero wait states, back-to-back with no idle between transfers.
        xfer(1, 32'h00, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b000, 0, rd, er);
        xfer(1, 32'h04, 1'b1, 32'h0BADF00D, 4'hF, 3'b000, 0, rd, er);
        xfer(1, 32'h00, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd, er);
        chk("ws0_r00", rd, 32'hA5A5A5A5);
        xfer(1, 32'h04, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd, er);
        chk("ws0_r04", rd, 32'h0BADF00D);

        // Protocol abort leaves the register untouched.
        xfer(0, 32'h08, 1'b1, 32'h11111111, 4'hF, 3'b000, 1, rd, er);
        idle(1);
        xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd, er);
        chk("abort_r08", rd, 32'h0);

        idle(2);
        rnd_burst(300);

        // Reset during the wait cycle of a write to 0x20.
        xfer(0, 32'h20, 1'b1, 32'h55AA55AA, 4'hF, 3'b000, 0, rd, er);
        psel = 2'b01;
        penable = 1'b0;
        paddr = 32'h20;
        pwrite = 1'b1;
        pwdata = 32'h77777777;
        pstrb = 4'hF;
        pprot = 3'b000;
        set_idle_exp();
        @(posedge pclk); #1;
        penable = 1'b1;
        #2 preset_n = 1'b0;
        clear_model();
        #1;
        chk("rstmid_pready", 32'(pready[0]), 32'h0);
        chk("rstmid_pslverr", 32'(pslverr[0]), 32'h0);
        chk("rstmid_prdata", prdata[0], 32'h0);
        psel = '0;
        penable = 1'b0;
        @(posedge pclk);
        #3 preset_n = 1'b1;
        @(posedge pclk); #1;
        xfer(0, 32'h20, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd, er);
        chk("rstmid_r20", rd, 32'h0);

        rnd_burst(100);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
